// File: rtl/dcache_pkg.sv
// Shared types and address-field helpers for the L1 data cache sequencer.
package dcache_pkg;

   localparam int unsigned TAG_W     = 25;
   localparam int unsigned LINE_W    = 256;
   localparam int unsigned VALID_BIT = 24;
   localparam int unsigned DIRTY_BIT = 23;
   localparam int unsigned ATAG_W    = 23;
   localparam int unsigned INDEX_W   = 4;
   localparam int unsigned WSEL_W    = 3;

   typedef enum logic [2:0] {
      IDLE,
      MISS,
      WRITEBACK,
      ALLOCATE,
      REFILL
   } state_t;

   function automatic logic [ATAG_W-1:0] addr_tag(input logic [31:0] addr);
      return addr[31:9];
   endfunction

   function automatic logic [INDEX_W-1:0] addr_index(input logic [31:0] addr);
      return addr[8:5];
   endfunction

   function automatic logic [WSEL_W-1:0] addr_word(input logic [31:0] addr);
      return addr[4:2];
   endfunction

endpackage

// File: rtl/dcache_word_mux.sv
// Word select for loads and single-word merge for stores on one cache line.
module dcache_word_mux
   import dcache_pkg::*;
(
   input  logic [LINE_W-1:0] line_i,
   input  logic [WSEL_W-1:0] word_i,
   input  logic [31:0]       wdata_i,
   output logic [31:0]       rdata_o,
   output logic [LINE_W-1:0] line_o
);

   logic [7:0] bit_base;

   assign bit_base = {word_i, 5'b0};

   always_comb begin
      rdata_o                 = line_i[bit_base +: 32];
      line_o                  = line_i;
      line_o[bit_base +: 32]  = wdata_i;
   end

endmodule

// File: rtl/dcache_ctrl.sv
// Hit/miss sequencer between the CPU memory stage, the cache tag/data SRAM
// and off-chip memory: write-back, write-allocate, CPU stalled during misses.
module dcache_ctrl #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned LINE_W = 256,
   parameter int unsigned TAG_W  = 25
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              cpu_req_i,
   input  logic              cpu_we_i,
   input  logic [ADDR_W-1:0] cpu_addr_i,
   input  logic [31:0]       cpu_data_i,
   output logic [31:0]       cpu_data_o,
   output logic              cpu_stall_o,
   output logic              sram_enable_o,
   output logic              sram_write_o,
   output logic [3:0]        sram_addr_o,
   output logic [TAG_W-1:0]  sram_tag_o,
   output logic [LINE_W-1:0] sram_data_o,
   input  logic [TAG_W-1:0]  sram_tag_i,
   input  logic [LINE_W-1:0] sram_data_i,
   input  logic              sram_hit_i,
   output logic              mem_enable_o,
   output logic              mem_write_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [LINE_W-1:0] mem_data_o,
   input  logic [LINE_W-1:0] mem_data_i,
   input  logic              mem_ack_i
);

   import dcache_pkg::*;

   state_t              state_q, state_d;
   logic [ATAG_W-1:0]   tag_q;
   logic [INDEX_W-1:0]  index_q;
   logic [TAG_W-1:0]    vtag_q;
   logic [LINE_W-1:0]   vline_q;
   logic [LINE_W-1:0]   fline_q;
   logic [31:0]         rd_word;
   logic [LINE_W-1:0]   merged_line;
   logic                lookup_hit;
   logic                lookup_miss;
   logic                victim_dirty;
   logic                unused_addr_lsbs;

   assign unused_addr_lsbs = ^cpu_addr_i[1:0];
   assign lookup_hit       = cpu_req_i & sram_hit_i;
   assign lookup_miss      = cpu_req_i & ~sram_hit_i;
   assign victim_dirty     = sram_tag_i[VALID_BIT] & sram_tag_i[DIRTY_BIT];

   dcache_word_mux u_word_mux (
      .line_i  (sram_data_i),
      .word_i  (addr_word(cpu_addr_i)),
      .wdata_i (cpu_data_i),
      .rdata_o (rd_word),
      .line_o  (merged_line)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         tag_q   <= '0;
         index_q <= '0;
         vtag_q  <= '0;
         vline_q <= '0;
         fline_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (lookup_miss) begin
                  tag_q   <= addr_tag(cpu_addr_i);
                  index_q <= addr_index(cpu_addr_i);
               end
            end
            MISS: begin
               vtag_q  <= sram_tag_i;
               vline_q <= sram_data_i;
            end
            ALLOCATE: begin
               if (mem_ack_i) begin
                  fline_q <= mem_data_i;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:      if (lookup_miss) state_d = MISS;
         MISS:      state_d = victim_dirty ? WRITEBACK : ALLOCATE;
         WRITEBACK: if (mem_ack_i) state_d = ALLOCATE;
         ALLOCATE:  if (mem_ack_i) state_d = REFILL;
         REFILL:    state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   // Lookup request kept apart from the hit-dependent outputs so the SRAM's
   // hit path never feeds back into its own address/tag. The dirty bit tracks
   // cpu_we_i during lookups; it only lands in the SRAM on a store hit.
   always_comb begin
      sram_enable_o = 1'b0;
      sram_addr_o   = index_q;
      sram_tag_o    = '0;
      case (state_q)
         IDLE: begin
            sram_enable_o = cpu_req_i;
            sram_addr_o   = addr_index(cpu_addr_i);
            sram_tag_o    = {1'b1, cpu_we_i, addr_tag(cpu_addr_i)};
         end
         MISS, REFILL: begin
            sram_enable_o = 1'b1;
            sram_tag_o    = {1'b1, 1'b0, tag_q};
         end
         default: ;
      endcase
   end

   always_comb begin
      cpu_data_o   = '0;
      cpu_stall_o  = 1'b1;
      sram_write_o = 1'b0;
      sram_data_o  = '0;
      mem_enable_o = 1'b0;
      mem_write_o  = 1'b0;
      mem_addr_o   = '0;
      mem_data_o   = '0;
      case (state_q)
         IDLE: begin
            cpu_stall_o = lookup_miss;
            if (lookup_hit) begin
               if (cpu_we_i) begin
                  sram_write_o = 1'b1;
                  sram_data_o  = merged_line;
               end else begin
                  cpu_data_o = rd_word;
               end
            end
         end
         WRITEBACK: begin
            mem_enable_o = 1'b1;
            mem_write_o  = 1'b1;
            mem_addr_o   = {vtag_q[ATAG_W-1:0], index_q, 5'b0};
            mem_data_o   = vline_q;
         end
         ALLOCATE: begin
            mem_enable_o = 1'b1;
            mem_addr_o   = {tag_q, index_q, 5'b0};
         end
         REFILL: begin
            sram_write_o = 1'b1;
            sram_data_o  = fline_q;
         end
         default: ;
      endcase
   end

endmodule
